dyn_phase_step_ctrl_tmr: RTL and testbench
==========================================

Name: dyn_phase_step_ctrl_tmr

Overview:
Triplicated (TMR) controller for MMCM/DCM dynamic phase shift. Accepts a signed multi-step phase request and issues one PSEN pulse per step with PSINCDEC direction, waiting for PS_DONE between steps. Adds PS_DONE timeout, loss-of-lock abort, safe recovery from illegal states and a saturating TMR error counter. Sits between the clock-phase control registers and the clock manager PS port.

Parameters:
STEP_W, 8, width of signed step request PH_STEPS; magnitude range 1..2^(STEP_W-1)
ERR_CNT_W, 16, width of TMR error counter
TMO_W, 10, width of PS_DONE timeout counter
DONE_TMO, 1023, cycles spent in W4_PSDone before timeout; must be < 2^TMO_W

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
LOCKED  in  1  clock manager lock
PH_REQ  in  1  single-cycle request strobe
PH_STEPS  in  STEP_W  signed step count; positive = increment
PS_DONE  in  1  clock manager step-complete pulse
BUSY  out  1  sequence in progress
PSEN  out  1  phase-shift enable, one-cycle pulse
PSINCDEC  out  1  1 = increment, 0 = decrement
PS_ERR  out  1  sticky: last sequence aborted (timeout or lock loss)
STEPS_LEFT  out  STEP_W  voted remaining-step count
DYN_PHS_STATE  out  3  voted state code
TMR_ERR_COUNT  out  ERR_CNT_W  voted error count

Behaviour:
- Reset (RST_N low, async): state Idle; BUSY, PSEN, PSINCDEC, PS_ERR = 0; STEPS_LEFT, timeout and error counters = 0.
- State codes: Idle=0, Inc_Dec=1, Standby=2, W4Lock=3, W4_PSDone=4. Codes 5-7 -> Idle on the next clock; never X.
- Idle -> W4Lock unconditionally.
- W4Lock: LOCKED=1 -> Standby; else stay.
- Standby: PH_REQ=1 and PH_STEPS!=0 -> Inc_Dec. On entry: STEPS_LEFT=|PH_STEPS| (unsigned; -2^(STEP_W-1) yields 2^(STEP_W-1)), PSINCDEC=~PH_STEPS[MSB], PS_ERR cleared. PH_STEPS=0 -> ignored, PS_ERR unchanged.
- PH_REQ outside Standby: ignored, not queued.
- Inc_Dec (1 cycle): PSEN=1, BUSY=1, STEPS_LEFT decrements by 1, timeout counter cleared -> W4_PSDone.
- W4_PSDone: BUSY=1; timeout counter increments every cycle.
  - PS_DONE=1 and STEPS_LEFT!=0 -> Inc_Dec.
  - PS_DONE=1 and STEPS_LEFT==0 -> Standby.
  - Counter reaches DONE_TMO without PS_DONE -> Standby, PS_ERR=1, STEPS_LEFT=0.
  - PS_DONE in the same cycle as the terminal count: PS_DONE wins.
- LOCKED=0 in Standby, Inc_Dec or W4_PSDone -> W4Lock. If sequence in progress: STEPS_LEFT=0, PS_ERR=1.
- BUSY and PSEN are registers decoded from next state: asserted in the same cycle the state register holds Inc_Dec/W4_PSDone. No combinational path from inputs to outputs.
- TMR: state, STEPS_LEFT, PSINCDEC, PS_ERR, timeout counter, BUSY, PSEN and error counter are each held in 3 copies. Next-state logic uses the voted values. Outputs are majority-voted.
- Error detect: any bit disagreement among the copies of any triplicated register in a cycle -> voted error count +1 (once per cycle), saturating at all-ones (no wrap).

Optional Feature:
PHASE_POS_TRACK_EN. Defined: adds output PHASE_POS (signed, STEP_W+4 bits), triplicated, reset 0, +1/-1 per PSINCDEC on each accepted PS_DONE, saturating at signed max/min. Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package dyn_phs_pkg: state-code constants, state width (3), illegal-state recovery constant (Idle).
- Sub-module tmr_vote_w: parameter W; three W-bit inputs -> voted W-bit output plus 1-bit mismatch flag. Instanced per triplicated register.

Test Plan:
- Reset release, LOCKED held 0 for 5 cycles then 1 -> states 0,3,...,3,2; BUSY=0, PSEN=0.
- Standby, PH_REQ with PH_STEPS=+3, PS_DONE 4 cycles after each PSEN -> exactly 3 PSEN pulses, PSINCDEC=1, STEPS_LEFT 2,1,0, return to Standby, PS_ERR=0.
- PH_STEPS=-128 (STEP_W=8) -> STEPS_LEFT loads 128, PSINCDEC=0, 128 pulses; PH_STEPS=0 -> no PSEN.
- No PS_DONE after first PSEN (DONE_TMO=15) -> Standby after 15 cycles in W4_PSDone, PS_ERR=1. Repeat with PS_DONE on the terminal cycle -> no error.
- LOCKED drops mid-sequence -> W4Lock next cycle, STEPS_LEFT=0, PS_ERR=1, BUSY=0. PH_REQ during BUSY -> ignored.
- Force one state copy to 6 for one cycle -> TMR_ERR_COUNT +1, voted state unaffected. Force all copies to 6 -> Idle. Preload error count at all-ones and force a mismatch -> count stays all-ones.

Source files
------------

// File: rtl/dyn_phase_step_ctrl_tmr_pkg.sv
// Shared state encoding for the triplicated dynamic phase-shift step controller.
package dyn_phs_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_INC_DEC    = 3'd1,
    ST_STANDBY    = 3'd2,
    ST_W4_LOCK    = 3'd3,
    ST_W4_PS_DONE = 3'd4
  } dyn_phs_state_e;

  // Landing state for any code outside the legal set
  localparam dyn_phs_state_e ST_RECOVER = ST_IDLE;

endpackage

// File: rtl/dyn_phase_step_ctrl_tmr_vote_w.sv
// Bitwise 2-of-3 majority voter with a disagreement flag for one triplicated register.
module tmr_vote_w #(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] voted_c,
  output logic         mismatch_c
);

  assign voted_c    = (a & b) | (b & c) | (a & c);
  assign mismatch_c = (a != b) || (a != c);

endmodule

// File: rtl/dyn_phase_step_ctrl_tmr.sv
// TMR controller issuing one PSEN per requested phase step, with PS_DONE timeout and lock-loss abort.
// Optional PHASE_POS tracking output is enabled by defining PHASE_POS_TRACK_EN.
module dyn_phase_step_ctrl_tmr
  import dyn_phs_pkg::*;
#(
  parameter int unsigned STEP_W    = 8,
  parameter int unsigned ERR_CNT_W = 16,
  parameter int unsigned TMO_W     = 10,
  parameter int unsigned DONE_TMO  = 1023
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 LOCKED,
  input  logic                 PH_REQ,
  input  logic [STEP_W-1:0]    PH_STEPS,
  input  logic                 PS_DONE,
  output logic                 BUSY,
  output logic                 PSEN,
  output logic                 PSINCDEC,
  output logic                 PS_ERR,
  output logic [STEP_W-1:0]    STEPS_LEFT,
  output logic [STATE_W-1:0]   DYN_PHS_STATE,
`ifdef PHASE_POS_TRACK_EN
  output logic signed [STEP_W+3:0] PHASE_POS,
`endif
  output logic [ERR_CNT_W-1:0] TMR_ERR_COUNT
);

  localparam int unsigned POS_W = STEP_W + 4;

  logic [STATE_W-1:0]   st_v, st_nxt;
  logic [STEP_W-1:0]    steps_v, steps_nxt, steps_abs;
  logic                 incdec_v, incdec_nxt;
  logic                 perr_v, perr_nxt;
  logic [TMO_W-1:0]     tmo_v, tmo_nxt;
  logic                 busy_v, busy_nxt;
  logic                 psen_v, psen_nxt;
  logic [ERR_CNT_W-1:0] ecnt_v, ecnt_nxt;
  logic [7:0]           mis_vec;
  logic                 pos_mis;
  logic                 any_mis;

  assign steps_abs = PH_STEPS[STEP_W-1] ? (~PH_STEPS) + STEP_W'(1) : PH_STEPS;
  assign any_mis   = (|mis_vec) | pos_mis;

  // Next-state and datapath decode, always from the voted copies
  always_comb begin
    st_nxt     = ST_RECOVER;
    steps_nxt  = steps_v;
    incdec_nxt = incdec_v;
    perr_nxt   = perr_v;
    tmo_nxt    = tmo_v;
    case (st_v)
      ST_IDLE:    st_nxt = ST_W4_LOCK;
      ST_W4_LOCK: st_nxt = LOCKED ? ST_STANDBY : ST_W4_LOCK;
      ST_STANDBY: begin
        if (!LOCKED) begin
          st_nxt = ST_W4_LOCK;
        end else if (PH_REQ && (PH_STEPS != '0)) begin
          st_nxt     = ST_INC_DEC;
          steps_nxt  = steps_abs;
          incdec_nxt = ~PH_STEPS[STEP_W-1];
          perr_nxt   = 1'b0;
        end else begin
          st_nxt = ST_STANDBY;
        end
      end
      ST_INC_DEC: begin
        if (!LOCKED) begin
          st_nxt    = ST_W4_LOCK;
          steps_nxt = '0;
          perr_nxt  = 1'b1;
        end else begin
          st_nxt    = ST_W4_PS_DONE;
          steps_nxt = steps_v - STEP_W'(1);
          tmo_nxt   = '0;
        end
      end
      ST_W4_PS_DONE: begin
        tmo_nxt = tmo_v + TMO_W'(1);
        if (!LOCKED) begin
          st_nxt    = ST_W4_LOCK;
          steps_nxt = '0;
          perr_nxt  = 1'b1;
        end else if (PS_DONE) begin
          st_nxt = (steps_v != '0) ? ST_INC_DEC : ST_STANDBY;
        end else if (tmo_v == TMO_W'(DONE_TMO - 1)) begin
          st_nxt    = ST_STANDBY;
          steps_nxt = '0;
          perr_nxt  = 1'b1;
        end else begin
          st_nxt = ST_W4_PS_DONE;
        end
      end
      default: st_nxt = ST_RECOVER;
    endcase
    busy_nxt = (st_nxt == ST_INC_DEC) || (st_nxt == ST_W4_PS_DONE);
    psen_nxt = (st_nxt == ST_INC_DEC);
    ecnt_nxt = (any_mis && (ecnt_v != '1)) ? ecnt_v + ERR_CNT_W'(1) : ecnt_v;
  end

`ifdef PHASE_POS_TRACK_EN
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  logic [POS_W-1:0] pos_v, pos_nxt;

  // Saturating position tracker, stepped on each accepted PS_DONE
  always_comb begin
    pos_nxt = pos_v;
    if ((st_v == ST_W4_PS_DONE) && LOCKED && PS_DONE) begin
      if (incdec_v) begin
        if (pos_v != POS_MAX) pos_nxt = pos_v + POS_W'(1);
      end else if (pos_v != POS_MIN) begin
        pos_nxt = pos_v - POS_W'(1);
      end
    end
  end
`endif

  // Three independent register copies fed from the same voted next values
  for (genvar i = 0; i < 3; i++) begin : g_tmr
    logic [STATE_W-1:0]   state_q;
    logic [STEP_W-1:0]    steps_q;
    logic                 incdec_q;
    logic                 perr_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 busy_q;
    logic                 psen_q;
    logic [ERR_CNT_W-1:0] ecnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q  <= ST_IDLE;
        steps_q  <= '0;
        incdec_q <= 1'b0;
        perr_q   <= 1'b0;
        tmo_q    <= '0;
        busy_q   <= 1'b0;
        psen_q   <= 1'b0;
        ecnt_q   <= '0;
      end else begin
        state_q  <= st_nxt;
        steps_q  <= steps_nxt;
        incdec_q <= incdec_nxt;
        perr_q   <= perr_nxt;
        tmo_q    <= tmo_nxt;
        busy_q   <= busy_nxt;
        psen_q   <= psen_nxt;
        ecnt_q   <= ecnt_nxt;
      end
    end

`ifdef PHASE_POS_TRACK_EN
    logic [POS_W-1:0] pos_q;
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pos_q <= '0;
      else        pos_q <= pos_nxt;
    end
`endif
  end

  tmr_vote_w #(.W(STATE_W)) u_vote_state (
    .a(g_tmr[0].state_q), .b(g_tmr[1].state_q), .c(g_tmr[2].state_q),
    .voted_c(st_v), .mismatch_c(mis_vec[0]));
  tmr_vote_w #(.W(STEP_W)) u_vote_steps (
    .a(g_tmr[0].steps_q), .b(g_tmr[1].steps_q), .c(g_tmr[2].steps_q),
    .voted_c(steps_v), .mismatch_c(mis_vec[1]));
  tmr_vote_w #(.W(1)) u_vote_incdec (
    .a(g_tmr[0].incdec_q), .b(g_tmr[1].incdec_q), .c(g_tmr[2].incdec_q),
    .voted_c(incdec_v), .mismatch_c(mis_vec[2]));
  tmr_vote_w #(.W(1)) u_vote_perr (
    .a(g_tmr[0].perr_q), .b(g_tmr[1].perr_q), .c(g_tmr[2].perr_q),
    .voted_c(perr_v), .mismatch_c(mis_vec[3]));
  tmr_vote_w #(.W(TMO_W)) u_vote_tmo (
    .a(g_tmr[0].tmo_q), .b(g_tmr[1].tmo_q), .c(g_tmr[2].tmo_q),
    .voted_c(tmo_v), .mismatch_c(mis_vec[4]));
  tmr_vote_w #(.W(1)) u_vote_busy (
    .a(g_tmr[0].busy_q), .b(g_tmr[1].busy_q), .c(g_tmr[2].busy_q),
    .voted_c(busy_v), .mismatch_c(mis_vec[5]));
  tmr_vote_w #(.W(1)) u_vote_psen (
    .a(g_tmr[0].psen_q), .b(g_tmr[1].psen_q), .c(g_tmr[2].psen_q),
    .voted_c(psen_v), .mismatch_c(mis_vec[6]));
  tmr_vote_w #(.W(ERR_CNT_W)) u_vote_ecnt (
    .a(g_tmr[0].ecnt_q), .b(g_tmr[1].ecnt_q), .c(g_tmr[2].ecnt_q),
    .voted_c(ecnt_v), .mismatch_c(mis_vec[7]));

`ifdef PHASE_POS_TRACK_EN
  tmr_vote_w #(.W(POS_W)) u_vote_pos (
    .a(g_tmr[0].pos_q), .b(g_tmr[1].pos_q), .c(g_tmr[2].pos_q),
    .voted_c(pos_v), .mismatch_c(pos_mis));
  assign PHASE_POS = pos_v;
`else
  assign pos_mis = 1'b0;
`endif

  assign BUSY          = busy_v;
  assign PSEN          = psen_v;
  assign PSINCDEC      = incdec_v;
  assign PS_ERR        = perr_v;
  assign STEPS_LEFT    = steps_v;
  assign DYN_PHS_STATE = st_v;
  assign TMR_ERR_COUNT = ecnt_v;

endmodule

// File: tb/tb_dyn_phase_step_ctrl_tmr.sv
// Directed self-checking bench for dyn_phase_step_ctrl_tmr (DONE_TMO shortened to 15).
module tb_dyn_phase_step_ctrl_tmr;

  localparam int unsigned STEP_W    = 8;
  localparam int unsigned ERR_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 locked;
  logic                 ph_req;
  logic [STEP_W-1:0]    ph_steps;
  logic                 ps_done;
  logic                 busy, psen, psincdec, ps_err;
  logic [STEP_W-1:0]    steps_left;
  logic [2:0]           dyn_phs_state;
  logic [ERR_CNT_W-1:0] tmr_err_count;
`ifdef PHASE_POS_TRACK_EN
  logic signed [STEP_W+3:0] phase_pos;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dyn_phase_step_ctrl_tmr #(
    .STEP_W(STEP_W), .ERR_CNT_W(ERR_CNT_W), .TMO_W(10), .DONE_TMO(15)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .LOCKED(locked), .PH_REQ(ph_req),
    .PH_STEPS(ph_steps), .PS_DONE(ps_done), .BUSY(busy), .PSEN(psen),
    .PSINCDEC(psincdec), .PS_ERR(ps_err), .STEPS_LEFT(steps_left),
    .DYN_PHS_STATE(dyn_phs_state),
`ifdef PHASE_POS_TRACK_EN
    .PHASE_POS(phase_pos),
`endif
    .TMR_ERR_COUNT(tmr_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [STEP_W-1:0] steps);
    ph_req   = 1'b1;
    ph_steps = steps;
    tick();
    ph_req   = 1'b0;
  endtask

  // Drives PS_DONE four cycles after every PSEN and checks each step
  task automatic run_steps(input int n, input logic inc);
    for (int k = 0; k < n; k++) begin
      chk("seq_state_incdec", 32'(dyn_phs_state), 32'd1);
      chk("seq_psen_high", 32'(psen), 32'd1);
      chk("seq_busy", 32'(busy), 32'd1);
      chk("seq_left_pre", 32'(steps_left), 32'(n - k));
      chk("seq_dir", 32'(psincdec), 32'(inc));
      tick();
      chk("seq_state_wait", 32'(dyn_phs_state), 32'd4);
      chk("seq_psen_low", 32'(psen), 32'd0);
      chk("seq_left_post", 32'(steps_left), 32'(n - 1 - k));
      tick();
      tick();
      ps_done = 1'b1;
      tick();
      ps_done = 1'b0;
      chk("seq_next_state", 32'(dyn_phs_state), (k == n - 1) ? 32'd2 : 32'd1);
    end
    chk("seq_end_err", 32'(ps_err), 32'd0);
    chk("seq_end_busy", 32'(busy), 32'd0);
    tick();
    chk("seq_quiet_psen", 32'(psen), 32'd0);
    chk("seq_quiet_state", 32'(dyn_phs_state), 32'd2);
  endtask

  initial begin
    bit seen;
    rst_n    = 1'b0;
    locked   = 1'b0;
    ph_req   = 1'b0;
    ph_steps = '0;
    ps_done  = 1'b0;
    tick();
    chk("rst_state", 32'(dyn_phs_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psen", 32'(psen), 32'd0);
    chk("rst_incdec", 32'(psincdec), 32'd0);
    chk("rst_err", 32'(ps_err), 32'd0);
    chk("rst_left", 32'(steps_left), 32'd0);
    chk("rst_errcnt", 32'(tmr_err_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w4lock_state", 32'(dyn_phs_state), 32'd3);
      chk("w4lock_busy", 32'(busy), 32'd0);
    end
    locked = 1'b1;
    tick();
    chk("lock_standby", 32'(dyn_phs_state), 32'd2);
    chk("lock_psen", 32'(psen), 32'd0);

    // +3 steps
    start_req(8'd3);
    run_steps(3, 1'b1);

    // -128 steps: magnitude 128, decrement
    start_req(8'h80);
    chk("neg_max_left", 32'(steps_left), 32'd128);
    chk("neg_max_dir", 32'(psincdec), 32'd0);
    run_steps(128, 1'b0);

    // Zero-step request is dropped
    start_req(8'd0);
    chk("zero_state", 32'(dyn_phs_state), 32'd2);
    chk("zero_psen", 32'(psen), 32'd0);
    tick();
    chk("zero_psen2", 32'(psen), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);

    // Timeout: no PS_DONE, 15 cycles in W4_PSDone
    start_req(8'd2);
    chk("tmo_psen", 32'(psen), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("tmo_waiting", 32'(dyn_phs_state), 32'd4);
    end
    tick();
    chk("tmo_state", 32'(dyn_phs_state), 32'd2);
    chk("tmo_err", 32'(ps_err), 32'd1);
    chk("tmo_left", 32'(steps_left), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);

    // PS_DONE on the terminal cycle wins over timeout
    start_req(8'd2);
    chk("tmo_clr_err", 32'(ps_err), 32'd0);
    for (int i = 1; i <= 15; i++) tick();
    ps_done = 1'b1;
    tick();
    ps_done = 1'b0;
    chk("tmo_race_state", 32'(dyn_phs_state), 32'd1);
    chk("tmo_race_err", 32'(ps_err), 32'd0);
    chk("tmo_race_left", 32'(steps_left), 32'd1);
    tick();
    ps_done = 1'b1;
    tick();
    ps_done = 1'b0;
    chk("tmo_race_done", 32'(dyn_phs_state), 32'd2);
    chk("tmo_race_err2", 32'(ps_err), 32'd0);

    // Lock loss mid-sequence; request during BUSY ignored
    start_req(8'd3);
    tick();
    chk("lol_left", 32'(steps_left), 32'd2);
    ph_req   = 1'b1;
    ph_steps = 8'd5;
    tick();
    ph_req   = 1'b0;
    chk("busy_req_state", 32'(dyn_phs_state), 32'd4);
    chk("busy_req_left", 32'(steps_left), 32'd2);
    locked = 1'b0;
    tick();
    chk("lol_state", 32'(dyn_phs_state), 32'd3);
    chk("lol_left0", 32'(steps_left), 32'd0);
    chk("lol_err", 32'(ps_err), 32'd1);
    chk("lol_busy", 32'(busy), 32'd0);
    chk("lol_psen", 32'(psen), 32'd0);
    locked = 1'b1;
    tick();
    chk("relock_state", 32'(dyn_phs_state), 32'd2);
    tick();
    chk("no_queue_psen", 32'(psen), 32'd0);
    chk("no_queue_state", 32'(dyn_phs_state), 32'd2);
    chk("pre_tmr_cnt", 32'(tmr_err_count), 32'd0);

    // One corrupted state copy for one cycle
    force dut.g_tmr[1].state_q = 3'd6;
    #1;
    chk("seu_voted", 32'(dyn_phs_state), 32'd2);
    tick();
    force dut.g_tmr[1].state_q = 3'd2;
    chk("seu_cnt", 32'(tmr_err_count), 32'd1);
    chk("seu_state", 32'(dyn_phs_state), 32'd2);
    tick();
    release dut.g_tmr[1].state_q;
    chk("seu_cnt_hold", 32'(tmr_err_count), 32'd1);

    // All copies illegal -> recovers through Idle
    force dut.g_tmr[0].state_q = 3'd6;
    force dut.g_tmr[1].state_q = 3'd6;
    force dut.g_tmr[2].state_q = 3'd6;
    tick();
    release dut.g_tmr[0].state_q;
    release dut.g_tmr[1].state_q;
    release dut.g_tmr[2].state_q;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (dyn_phs_state == 3'd0) seen = 1'b1;
      else tick();
    end
    chk("illegal_to_idle", 32'(seen), 32'd1);
    chk("illegal_busy", 32'(busy), 32'd0);
    tick();
    chk("illegal_w4lock", 32'(dyn_phs_state), 32'd3);
    tick();
    chk("illegal_standby", 32'(dyn_phs_state), 32'd2);
    chk("illegal_cnt", 32'(tmr_err_count), 32'd1);

    // Saturation: preload all-ones, then inject a mismatch
    force dut.g_tmr[0].ecnt_q = 16'hFFFF;
    force dut.g_tmr[1].ecnt_q = 16'hFFFF;
    force dut.g_tmr[2].ecnt_q = 16'hFFFF;
    tick();
    release dut.g_tmr[0].ecnt_q;
    release dut.g_tmr[1].ecnt_q;
    release dut.g_tmr[2].ecnt_q;
    #1;
    chk("sat_preload", 32'(tmr_err_count), 32'h0000FFFF);
    force dut.g_tmr[0].state_q = 3'd6;
    tick();
    force dut.g_tmr[0].state_q = 3'd2;
    chk("sat_hold", 32'(tmr_err_count), 32'h0000FFFF);
    tick();
    release dut.g_tmr[0].state_q;
    chk("sat_hold2", 32'(tmr_err_count), 32'h0000FFFF);
    chk("sat_state", 32'(dyn_phs_state), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
